// File: rtl/exe_muldiv_sequencer_pkg.sv
// Shared definitions for the EXE-stage RV32M multiply/divide sequencer:
// funct3 op encodings, FSM state encoding and op classification helpers.
package exe_muldiv_sequencer_pkg;

  localparam int unsigned MD_XLEN = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FIXUP = 2'b10,
    ST_DONE  = 2'b11
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic op_is_rem(input md_op_e op);
    return op inside {MD_REM, MD_REMU};
  endfunction

  function automatic logic op_a_signed(input md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic op_b_signed(input md_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/exe_muldiv_sequencer_datapath.sv
// Magnitude datapath: shared hi/lo accumulators serve as product halves for
// multiply and as partial remainder / quotient for restoring divide.
module exe_muldiv_sequencer_datapath
  import exe_muldiv_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic            load,
  input  logic            load_fast,
  input  logic            step,
  input  logic            fix,
  output logic            fast,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_op_e          op_in;
  md_op_e          op_q, op_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] fast_res;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic            div_ok;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;
  logic [XLEN-1:0] fix_res;

  always_comb begin
    op_in = md_op_e'(op);
    a_neg = op_a_signed(op_in) & opa[XLEN-1];
    b_neg = op_b_signed(op_in) & opb[XLEN-1];
    a_mag = a_neg ? -opa : opa;
    b_mag = b_neg ? -opb : opb;
    fast  = op_is_div(op_in) &&
            ((opb == '0) || (op_b_signed(op_in) && (opa == MIN_NEG) && (opb == '1)));
    // Divide-by-zero takes precedence over signed overflow
    if (opb == '0) begin
      fast_res = op_is_rem(op_in) ? opa : '1;
    end else begin
      fast_res = op_is_rem(op_in) ? '0 : MIN_NEG;
    end
  end

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    // Partial remainder is always below the divisor, so bit XLEN of the
    // difference is a clean borrow flag.
    div_diff  = div_shift - {1'b0, b_q};
    div_ok    = ~div_diff[XLEN];
  end

  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
    rem_fix  = sign_a_q ? -hi_q : hi_q;
    case (op_q)
      MD_MUL:                     fix_res = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:            fix_res = quo_fix;
      default:                    fix_res = rem_fix;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;
    if (load) begin
      op_d     = op_in;
      sign_a_d = a_neg;
      sign_b_d = b_neg;
      hi_d     = '0;
      lo_d     = a_mag;
      b_d      = b_mag;
    end else if (step) begin
      if (op_is_div(op_q)) begin
        hi_d = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], div_ok};
      end else begin
        hi_d = mul_sum[XLEN:1];
        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
    if (load_fast) begin
      result_d = fast_res;
    end else if (fix) begin
      result_d = fix_res;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= MD_MUL;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/exe_muldiv_sequencer.sv
// RV32M multi-cycle sequencer for the EXE stage: FSM, iteration counter and
// pipeline stall/done handshake around the shared multiply/divide datapath.
module exe_muldiv_sequencer
  import exe_muldiv_sequencer_pkg::*;
#(
  parameter int unsigned XLEN  = MD_XLEN,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept;
  logic fast;
  logic dp_load, dp_load_fast, dp_step, dp_fix;

  assign accept = start & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (fast) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            cnt_d   = CNT_W'(XLEN - 1);
          end
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_FIXUP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FIXUP: state_d = flush ? ST_IDLE : ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A flushed FIXUP must not overwrite the previously delivered result
  always_comb begin
    stall        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    dp_load      = 1'b0;
    dp_load_fast = 1'b0;
    dp_step      = 1'b0;
    dp_fix       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall        = accept;
        dp_load      = accept;
        dp_load_fast = accept & fast;
      end
      ST_RUN: begin
        stall   = 1'b1;
        busy    = 1'b1;
        dp_step = 1'b1;
      end
      ST_FIXUP: begin
        stall  = 1'b1;
        busy   = 1'b1;
        dp_fix = ~flush;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  exe_muldiv_sequencer_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk       (clk),
    .reset_n   (reset_n),
    .op        (op),
    .opa       (opa),
    .opb       (opb),
    .load      (dp_load),
    .load_fast (dp_load_fast),
    .step      (dp_step),
    .fix       (dp_fix),
    .fast      (fast),
    .result    (result)
  );

endmodule

// File: tb/tb_exe_muldiv_sequencer.sv
// Randomized self-checking bench for exe_muldiv_sequencer against a plain
// 64-bit arithmetic reference of the RV32M rules.
module tb_exe_muldiv_sequencer;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          n_checks;
  int          n_errors;
  logic [31:0] last_res;

  exe_muldiv_sequencer #(
    .XLEN  (32),
    .CNT_W (6)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .opa     (opa),
    .opb     (opb),
    .flush   (flush),
    .stall   (stall),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sb, sq;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (o)
      OP_MUL:    begin p = ua * ub; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        sq = sa / sb;
        p  = sq;
        return p[31:0];
      end
      OP_DIVU: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      OP_REM: begin
        if (b == 0) return a;
        sq = sa % sb;
        p  = sq;
        return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit ref_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o != OP_DIV && o != OP_DIVU && o != OP_REM && o != OP_REMU) return 1'b0;
    if (b == 0) return 1'b1;
    return (o == OP_DIV || o == OP_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h00000000;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h00000001;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op; with hold=1, start stays high with scrambled inputs until done.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input bit hold, input string tag);
    int cyc;
    int stl;
    int exp_lat;
    bit seen;
    exp_lat = ref_fast(o, a, b) ? 1 : 34;
    @(negedge clk);
    op = o; opa = a; opb = b; start = 1'b1;
    #1;
    stl = stall ? 1 : 0;
    @(posedge clk);
    #1;
    if (hold) begin
      op  = 3'($urandom_range(0, 7));
      opa = $urandom;
      opb = $urandom;
    end else begin
      start = 1'b0;
    end
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
      if (done) seen = 1'b1;
      else if (stall) stl++;
    end
    start = 1'b0;
    check_eq({tag, " done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, " result"}, result, exp_r);
    check_eq({tag, " latency"}, cyc, exp_lat);
    check_eq({tag, " stall_cycles"}, stl, exp_lat);
    check_eq({tag, " stall_in_done"}, 32'(stall), 32'd0);
    @(negedge clk);
    #1;
    check_eq({tag, " done_width"}, 32'(done), 32'd0);
    check_eq({tag, " result_held"}, result, exp_r);
    last_res = exp_r;
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    string       name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int n_done;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    op       = '0;
    opa      = '0;
    opb      = '0;
    last_res = '0;

    #3;
    check_eq("reset busy",   32'(busy),  32'd0);
    check_eq("reset stall",  32'(stall), 32'd0);
    check_eq("reset done",   32'(done),  32'd0);
    check_eq("reset result", result,     32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    vecs.push_back('{OP_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7_m3"});
    vecs.push_back('{OP_MULH,   32'h80000000,   32'h80000000, 32'h40000000, "mulh_min"});
    vecs.push_back('{OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max"});
    vecs.push_back('{OP_MULHSU, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, "mulhsu_m1_2"});
    vecs.push_back('{OP_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, "div_m7_2"});
    vecs.push_back('{OP_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, "rem_m7_2"});
    vecs.push_back('{OP_DIVU,   32'd100,        32'd7,        32'd14,       "divu_100_7"});
    vecs.push_back('{OP_REMU,   32'd100,        32'd7,        32'd2,        "remu_100_7"});
    vecs.push_back('{OP_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, "divu_by0"});
    vecs.push_back('{OP_REM,    32'd5,          32'd0,        32'd5,        "rem_by0"});
    vecs.push_back('{OP_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, "div_ovf"});
    vecs.push_back('{OP_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        "rem_ovf"});
    foreach (vecs[i]) run_op(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].r, 1'b0, vecs[i].name);

    // Flush during the 10th RUN cycle
    @(negedge clk);
    op = OP_MUL; opa = 32'h12345678; opb = 32'h9ABCDEF1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    #1;
    check_eq("flush busy_next",  32'(busy),  32'd0);
    check_eq("flush stall_next", 32'(stall), 32'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (done) n_done++;
    end
    check_eq("flush no_done", n_done, 0);
    check_eq("flush result_kept", result, last_res);
    run_op(OP_MUL, 32'd3, 32'd4, 32'd12, 1'b0, "mul_after_flush");

    // Flush in IDLE suppresses start
    @(negedge clk);
    op = OP_DIVU; opa = 32'd50; opb = 32'd5; start = 1'b1; flush = 1'b1;
    #1;
    check_eq("idle_flush stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    #1;
    check_eq("idle_flush busy", 32'(busy), 32'd0);
    check_eq("idle_flush result", result, last_res);

    // Start held while busy must not re-latch operands
    run_op(OP_MUL, 32'd6, 32'd7, 32'd42, 1'b1, "hold_start");

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = rnd_operand();
      rb = rnd_operand();
      run_op(ro, ra, rb, ref_md(ro, ra, rb), 1'b0, "rand");
    end

    // Asynchronous reset between edges mid-RUN
    @(negedge clk);
    op = OP_DIVU; opa = 32'hDEADBEEF; opb = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst busy",   32'(busy),  32'd0);
    check_eq("async_rst stall",  32'(stall), 32'd0);
    check_eq("async_rst done",   32'(done),  32'd0);
    check_eq("async_rst result", result,     32'd0);
    last_res = '0;
    @(negedge clk);
    reset_n = 1'b1;
    run_op(OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exe_muldiv_sequencer.md
Name: exe_muldiv_sequencer

Overview:
Multi-cycle sequencer for RV32M multiply/divide operations issued into the EXE stage. It holds the EXE stage with a stall while a 32-iteration shift-add multiply or restoring divide runs. It then presents a one-cycle result for the EXE/MEM boundary to capture. Its inputs are the forwarded EXE operands (OpA / OpB after the forwarding muxes); its result is muxed onto the EXE ALU result path.

Parameters:
XLEN, 32, operand/result width; only 32 is verified.
CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  reset; asynchronous, active-low
start  in  1  M-extension instruction valid in EXE; sampled only in IDLE
op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
opa  in  XLEN  forwarded rs1 value
opb  in  XLEN  forwarded rs2 value
flush  in  1  synchronous abort (branch/exception flush of EXE)
stall  out  1  hold PC, IF/ID, ID/EXE; combinational
busy  out  1  state not IDLE
done  out  1  result valid, one-cycle pulse
result  out  XLEN  selected result; held until next accepted start

Behaviour:
- Reset (reset_n low, any time including mid-operation): state=IDLE; counter=0; accumulators=0; result=0; done=0; busy=0. stall=0 whenever start=0.
- States: IDLE, RUN, FIXUP, DONE.
- IDLE:
  - start=1 latches op, operand magnitudes and sign flags.
  - Signed operands: MULH, MULHSU (opa only), DIV, REM. Negative signed operands are converted to two's-complement magnitude.
  - Normal ops go to RUN with counter=XLEN-1.
- Fast path: divide ops with opb==0, or signed DIV/REM with opa=0x80000000 and opb=0xFFFFFFFF, go IDLE->DONE directly.
  - div-by-zero: quotient=all ones, remainder=opa.
  - overflow: quotient=0x80000000, remainder=0.
- RUN: one iteration per cycle. Counter decrements; leave to FIXUP when counter==0 (XLEN cycles in RUN).
  - Multiply: 2*XLEN-bit shift-add on magnitudes, LSB of multiplier first.
  - Divide: restoring, MSB first; XLEN+1-bit partial remainder subtract; quotient bit = no-borrow.
- FIXUP (1 cycle):
  - Product negated if operand signs differ.
  - Quotient negated if signs differ; remainder takes dividend sign.
  - Result select: MUL low word; MULH/MULHSU/MULHU high word; DIV/DIVU quotient; REM/REMU remainder. Registered into result.
- DONE (1 cycle): done=1, stall=0 so the pipeline advances and EXE/MEM captures result. Next state IDLE. A start in the DONE cycle is ignored; the next instruction is taken from IDLE.
- Latency:
  - Normal: start edge E0; done high in the cycle after edge E0+XLEN+1 (34 cycles for XLEN=32).
  - Fast path: done high in the cycle after E0.
- stall = (IDLE & start & ~flush) | RUN | FIXUP | (DONE-bound fast-path state, excluding DONE). stall is high from the start cycle through the cycle before done (34 cycles normal, 1 cycle fast path).
- flush:
  - In RUN/FIXUP: next state IDLE, done never asserted, result keeps its previous value.
  - In IDLE with start: start ignored.
  - In DONE: done still pulses; the pipeline discards it.
- start while busy: ignored; operands are not re-latched.
- Arithmetic wraps modulo 2^XLEN; no exceptions are raised.

Decomposition:
- Shared package (cpu_pkg): op encodings MD_MUL..MD_REMU, state encoding constants, XLEN.
- One sub-module, muldiv_datapath: accumulators, shift/add/subtract step and sign fixup. The sequencer keeps the FSM, counter and stall/done logic.

Test Plan:
- MUL opa=7, opb=0xFFFFFFFD -> result 0xFFFFFFEB; stall high 34 cycles; done pulse exactly 1 cycle, 34 cycles after start.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, with done 1 cycle after start. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, also 1-cycle.
- flush at RUN iteration 10 -> IDLE next cycle, no done, result unchanged. Following MUL 3*4 -> 12 with full 34-cycle latency.
- reset_n low mid-RUN (asynchronous, between edges) -> busy/stall/done/result = 0 immediately. start held during busy -> no re-latch; first operands' result returned.
